// File: rtl/adc_resp_pkg.sv
// Shared types and default sizing for the serial ADC responder.
package adc_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CONVERT
    } adc_state_e;

    localparam int ADC_DATA_W      = 8;
    localparam int ADC_CONV_CYCLES = 1700;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous pin, followed by a one-flop
// edge detector producing single-cycle rise/fall pulses.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    // Flops reset high so idle-high pins produce no spurious edge.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_reg[gi] <= 1'b1;
                    else     sync_reg[gi] <= d;
                end
            end else begin : g_chain
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_reg[gi] <= 1'b1;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_reg <= 1'b1;
        else     prev_reg <= sync_reg[STAGES-1];
    end

    assign rise = sync_reg[STAGES-1] & ~prev_reg;
    assign fall = ~sync_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/adc_serial_responder.sv
// Slave-side serial ADC model: shifts the last converted sample out on
// falling adclk edges while cs_n is low, then models the conversion time.
module adc_serial_responder
    import adc_resp_pkg::*;
#(
    parameter int DATA_W      = ADC_DATA_W,
    parameter int CONV_CYCLES = ADC_CONV_CYCLES,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              adclk,
    input  logic [DATA_W-1:0] sample_in,
    output logic              ad_out,
    output logic              busy,
    output logic              frame_done,
    output logic              short_frame,
    output logic              conv_abort
);

    localparam int NF_W = $clog2(DATA_W + 1);
    localparam int CC_W = $clog2(CONV_CYCLES + 1);
    localparam logic [NF_W-1:0] NF_LAST = NF_W'(DATA_W - 1);
    localparam logic [NF_W-1:0] NF_FULL = NF_W'(DATA_W);
    localparam logic [CC_W-1:0] CC_LAST = CC_W'(CONV_CYCLES - 1);

    logic cs_rise, cs_fall, sck_fall, sck_rise_unused;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (adclk),
        .rise (sck_rise_unused),
        .fall (sck_fall)
    );

    adc_state_e        state_reg, state_next;
    logic [DATA_W-1:0] held_reg, held_next;
    logic [DATA_W-1:0] shreg_reg, shreg_next;
    logic [NF_W-1:0]   nfall_reg, nfall_next;
    logic [CC_W-1:0]   conv_cnt_reg, conv_cnt_next;
    logic              ad_out_reg, ad_out_next;
    logic              frame_done_reg, frame_done_next;
    logic              short_frame_reg, short_frame_next;
    logic              conv_abort_reg, conv_abort_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            held_reg        <= '0;
            shreg_reg       <= '0;
            nfall_reg       <= '0;
            conv_cnt_reg    <= '0;
            ad_out_reg      <= 1'b0;
            frame_done_reg  <= 1'b0;
            short_frame_reg <= 1'b0;
            conv_abort_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            held_reg        <= held_next;
            shreg_reg       <= shreg_next;
            nfall_reg       <= nfall_next;
            conv_cnt_reg    <= conv_cnt_next;
            ad_out_reg      <= ad_out_next;
            frame_done_reg  <= frame_done_next;
            short_frame_reg <= short_frame_next;
            conv_abort_reg  <= conv_abort_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        held_next        = held_reg;
        shreg_next       = shreg_reg;
        nfall_next       = nfall_reg;
        conv_cnt_next    = conv_cnt_reg;
        ad_out_next      = ad_out_reg;
        frame_done_next  = 1'b0;
        short_frame_next = 1'b0;
        conv_abort_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cs_fall) begin
                    shreg_next  = held_reg;
                    ad_out_next = held_reg[DATA_W-1];
                    nfall_next  = '0;
                    state_next  = SHIFT;
                end
            end

            SHIFT: begin
                // cs_rise takes priority so a coincident adclk fall never shifts.
                if (cs_rise) begin
                    if (nfall_reg >= NF_LAST) frame_done_next  = 1'b1;
                    else                      short_frame_next = 1'b1;
                    conv_cnt_next = CC_LAST;
                    state_next    = CONVERT;
                end else if (sck_fall) begin
                    if (nfall_reg < NF_LAST) begin
                        shreg_next  = {shreg_reg[DATA_W-2:0], 1'b0};
                        ad_out_next = shreg_reg[DATA_W-2];
                        nfall_next  = nfall_reg + 1'b1;
                    end else begin
                        ad_out_next = 1'b0;
                        if (nfall_reg < NF_FULL) nfall_next = nfall_reg + 1'b1;
                    end
                end
            end

            CONVERT: begin
                if (cs_fall) begin
                    conv_abort_next = 1'b1;
                    shreg_next      = held_reg;
                    ad_out_next     = held_reg[DATA_W-1];
                    nfall_next      = '0;
                    state_next      = SHIFT;
                end else if (conv_cnt_reg == '0) begin
                    held_next  = sample_in;
                    state_next = IDLE;
                end else begin
                    conv_cnt_next = conv_cnt_reg - 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign ad_out      = ad_out_reg;
    assign busy        = (state_reg == CONVERT);
    assign frame_done  = frame_done_reg;
    assign short_frame = short_frame_reg;
    assign conv_abort  = conv_abort_reg;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder: drives master-style frames and
// checks shifted bits, pulses and conversion timing against hand values.
module tb_adc_serial_responder;
    import adc_resp_pkg::*;

    localparam int PH = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1;
    logic       adclk = 1'b0;
    logic [7:0] sample_in = 8'h00;
    logic       ad_out, busy, frame_done, short_frame, conv_abort;

    int checks = 0;
    int failures = 0;
    int done_total = 0, short_total = 0, abort_total = 0, busy_total = 0;

    adc_serial_responder dut (
        .clk         (clk),
        .rst         (rst),
        .cs_n        (cs_n),
        .adclk       (adclk),
        .sample_in   (sample_in),
        .ad_out      (ad_out),
        .busy        (busy),
        .frame_done  (frame_done),
        .short_frame (short_frame),
        .conv_abort  (conv_abort)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done)  done_total++;
        if (short_frame) short_total++;
        if (conv_abort)  abort_total++;
        if (busy)        busy_total++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master frame: every rising adclk samples ad_out, every rise is followed by a fall.
    task automatic run_frame(input int nrise, input bit coincide, output logic [15:0] bits);
        bits = '0;
        cs_n = 1'b0;
        tick(PH);
        for (int i = 0; i < nrise; i++) begin
            adclk = 1'b1;
            bits[i] = ad_out;
            tick(PH);
            adclk = 1'b0;
            if (coincide && i == nrise - 1) cs_n = 1'b1;
            tick(PH);
        end
        cs_n = 1'b1;
        tick(PH);
    endtask

    function automatic logic [7:0] to_byte(input logic [15:0] bits);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[7-j] = bits[j];
        return b;
    endfunction

    task automatic wait_conv(input int base, output int cycles);
        bit seen = 0;
        for (int k = 0; k < 3000; k++) begin
            tick(1);
            if (!busy && (busy_total - base) > 0) begin
                seen = 1;
                break;
            end
        end
        cycles = busy_total - base;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL conv_timeout: busy cycles=%0d required conversion to end", cycles);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        checks++;
        if (ad_out !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: ad_out=%b busy=%b required 0 0", ad_out, busy);
        end
        checks++;
        if ({frame_done, short_frame, conv_abort} !== 3'b000) begin
            failures++;
            $display("FAIL reset_pulses: got %b required 000", {frame_done, short_frame, conv_abort});
        end
        checks++;
        if (dut.state_reg !== IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d required IDLE", dut.state_reg);
        end
        rst = 1'b0;
        tick(PH);
        checks++;
        if (busy !== 1'b0 || ad_out !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: ad_out=%b busy=%b required 0 0", ad_out, busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_first_frame;
        logic [15:0] bits;
        int d0, s0, b0, cyc;
        sample_in = 8'hA5;
        d0 = done_total; s0 = short_total; b0 = busy_total;
        run_frame(8, 0, bits);
        checks++;
        if (to_byte(bits) !== 8'h00) begin
            failures++;
            $display("FAIL first_frame_data: got %h required 00", to_byte(bits));
        end
        checks++;
        if (done_total - d0 != 1 || short_total - s0 != 0) begin
            failures++;
            $display("FAIL first_frame_pulses: done=%0d short=%0d required 1 0", done_total - d0, short_total - s0);
        end
        wait_conv(b0, cyc);
        checks++;
        if (cyc != 1700) begin
            failures++;
            $display("FAIL busy_length: got %0d required 1700", cyc);
        end
        $display("frame1 data=%h busy=%0d", to_byte(bits), cyc);
    endtask

    task automatic test_full_frame_extra;
        logic [15:0] bits;
        int d0, b0, cyc;
        sample_in = 8'h11;
        d0 = done_total; b0 = busy_total;
        run_frame(10, 0, bits);
        checks++;
        if (to_byte(bits) !== 8'hA5) begin
            failures++;
            $display("FAIL second_frame_data: got %h required a5", to_byte(bits));
        end
        checks++;
        if (bits[9:8] !== 2'b00) begin
            failures++;
            $display("FAIL extra_edges: got %b required 00", bits[9:8]);
        end
        checks++;
        if (done_total - d0 != 1) begin
            failures++;
            $display("FAIL second_frame_done: got %0d required 1", done_total - d0);
        end
        wait_conv(b0, cyc);
        $display("frame2 data=%h extra=%b", to_byte(bits), bits[9:8]);
    endtask

    task automatic test_short_frame;
        logic [15:0] bits;
        int d0, s0, b0, cyc;
        d0 = done_total; s0 = short_total; b0 = busy_total;
        run_frame(3, 0, bits);
        checks++;
        if (bits[2:0] !== 3'b000) begin
            failures++;
            $display("FAIL short_data: got %b required 000", bits[2:0]);
        end
        checks++;
        if (short_total - s0 != 1 || done_total - d0 != 0) begin
            failures++;
            $display("FAIL short_pulses: short=%0d done=%0d required 1 0", short_total - s0, done_total - d0);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL short_busy: got %b required 1", busy);
        end
        wait_conv(b0, cyc);
        checks++;
        if (cyc != 1700) begin
            failures++;
            $display("FAIL short_busy_length: got %0d required 1700", cyc);
        end
        $display("short frame bits=%b busy=%0d", bits[2:0], cyc);
    endtask

    task automatic test_conv_abort;
        logic [15:0] bits;
        int a0, d0, b0, cyc;
        bit seen = 0;
        sample_in = 8'h3C;
        run_frame(8, 0, bits);
        for (int k = 0; k < 20; k++) begin
            if (busy) begin seen = 1; break; end
            tick(1);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL abort_busy_start: busy=%b required 1", busy);
        end
        tick(500);
        a0 = abort_total; d0 = done_total; b0 = busy_total;
        run_frame(8, 0, bits);
        checks++;
        if (abort_total - a0 != 1) begin
            failures++;
            $display("FAIL abort_pulse: got %0d required 1", abort_total - a0);
        end
        checks++;
        if (to_byte(bits) !== 8'h11) begin
            failures++;
            $display("FAIL abort_data: got %h required 11", to_byte(bits));
        end
        checks++;
        if (dut.held_reg !== 8'h11) begin
            failures++;
            $display("FAIL abort_held: got %h required 11", dut.held_reg);
        end
        checks++;
        if (done_total - d0 != 1) begin
            failures++;
            $display("FAIL abort_frame_done: got %0d required 1", done_total - d0);
        end
        wait_conv(b0, cyc);
        $display("abort data=%h", to_byte(bits));
    endtask

    task automatic test_reset_mid_shift;
        logic [15:0] bits;
        int b0, cyc;
        // held is 0x3C here: after two falls ad_out carries bit 5 = 1
        cs_n = 1'b0;
        tick(PH);
        for (int i = 0; i < 2; i++) begin
            adclk = 1'b1; tick(PH);
            adclk = 1'b0; tick(PH);
        end
        checks++;
        if (ad_out !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_bit: got %b required 1", ad_out);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ad_out !== 1'b0) begin
            failures++;
            $display("FAIL rst_ad_out: got %b required 0", ad_out);
        end
        checks++;
        if (dut.state_reg !== IDLE) begin
            failures++;
            $display("FAIL rst_state: got %0d required IDLE", dut.state_reg);
        end
        cs_n = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(PH);
        sample_in = 8'h02;
        b0 = busy_total;
        run_frame(8, 0, bits);
        checks++;
        if (to_byte(bits) !== 8'h00) begin
            failures++;
            $display("FAIL post_rst_data: got %h required 00", to_byte(bits));
        end
        wait_conv(b0, cyc);
        $display("reset mid-shift, next data=%h", to_byte(bits));
    endtask

    task automatic test_coincident;
        logic [15:0] bits;
        int d0, s0, b0, cyc;
        // held=0x02: after 6 falls ad_out=1; a seventh shift would make it 0
        d0 = done_total; s0 = short_total; b0 = busy_total;
        run_frame(7, 1, bits);
        checks++;
        if (short_total - s0 != 1 || done_total - d0 != 0) begin
            failures++;
            $display("FAIL coincide_short: short=%0d done=%0d required 1 0", short_total - s0, done_total - d0);
        end
        checks++;
        if (ad_out !== 1'b1) begin
            failures++;
            $display("FAIL coincide_no_shift: ad_out=%b required 1", ad_out);
        end
        wait_conv(b0, cyc);
        d0 = done_total; s0 = short_total; b0 = busy_total;
        run_frame(8, 1, bits);
        checks++;
        if (done_total - d0 != 1 || short_total - s0 != 0) begin
            failures++;
            $display("FAIL coincide_done: done=%0d short=%0d required 1 0", done_total - d0, short_total - s0);
        end
        checks++;
        if (to_byte(bits) !== 8'h02) begin
            failures++;
            $display("FAIL coincide_data: got %h required 02", to_byte(bits));
        end
        wait_conv(b0, cyc);
        $display("coincident edges data=%h", to_byte(bits));
    endtask

    initial begin
        test_reset;
        test_first_frame;
        test_full_frame_extra;
        test_short_frame;
        test_conv_abort;
        test_reset_mid_shift;
        test_coincident;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
